mux4: RTL and testbench

MUX4 -- requirements
Module: mux4

---
 rtl/mux4_pkg.sv | 13 +
 rtl/mux4_decoder2to4.sv | 26 ++
 rtl/mux4.sv | 65 ++++++
 tb/tb_mux4.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mux4_pkg.sv
// mux4_pkg -- shared definitions for the mux4 block.
//   SEL_I0..SEL_I3 : encodings of the 2-bit select input (source index).
//   MUX4_DEFAULT_WIDTH : default data width of mux4.
package mux4_pkg;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

  localparam int MUX4_DEFAULT_WIDTH = 1;

endpackage : mux4_pkg

// File: rtl/mux4_decoder2to4.sv
// decoder2to4 -- maps a 2-bit source index to a 4-bit one-hot vector.
//   select : input  [1:0]  source index (SEL_I0..SEL_I3)
//   onehot : output [3:0]  bit n set when select selects source n
// For any defined select exactly one line is high; an X/Z select drives
// all lines to X so that downstream data goes X in simulation.
module decoder2to4
  import mux4_pkg::*;
(
  input  logic [1:0] select,
  output logic [3:0] onehot
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves onehot
    // unassigned; otherwise a latch is inferred.
    onehot = '0;
    case (select)
      SEL_I0:  onehot = 4'b0001;
      SEL_I1:  onehot = 4'b0010;
      SEL_I2:  onehot = 4'b0100;
      SEL_I3:  onehot = 4'b1000;
      default: onehot = 'x;  // only reachable with X/Z select
    endcase
  end

endmodule : decoder2to4

// File: rtl/mux4.sv
// mux4 -- 4-to-1 multiplexer with optional registered output.
//   result   : output [WIDTH-1:0] combinational selected data
//   i0..i3   : input  [WIDTH-1:0] data candidates 0..3
//   select   : input  [1:0]       source index
//   clk      : input              rising-edge clock (registered path only)
//   rst      : input              async active-high reset (registered path only)
//   en       : input              load enable for result_q   (MUX4_REG_OUT_EN)
//   result_q : output [WIDTH-1:0] registered selected data   (MUX4_REG_OUT_EN)
// Build option: define MUX4_REG_OUT_EN to compile in the output register,
// en and result_q. Without it clk and rst stay as ports but are unused.
// The combinational path is a one-hot decode followed by per-bit AND-OR.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = MUX4_DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [1:0]       select,
  input  logic             clk,
  input  logic             rst
`ifdef MUX4_REG_OUT_EN
  ,
  input  logic             en,
  output logic [WIDTH-1:0] result_q
`endif
);

  logic [3:0] onehot;

  decoder2to4 u_decoder (
    .select (select),
    .onehot (onehot)
  );

  // Each one-hot line is replicated across the word and gates its source.
  always_comb begin
    result = ({WIDTH{onehot[0]}} & i0)
           | ({WIDTH{onehot[1]}} & i1)
           | ({WIDTH{onehot[2]}} & i2)
           | ({WIDTH{onehot[3]}} & i3);
  end

`ifdef MUX4_REG_OUT_EN
  // The register samples the same combinational result, so a select and
  // data change in one cycle is captured as one coherent value.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values.
    if (rst) begin
      result_q <= '0;
    end else if (en) begin
      result_q <= result;
    end
  end
`else
  // clk and rst are kept for interface compatibility only.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule : mux4

// File: tb/tb_mux4.sv
// tb_mux4 -- directed self-checking bench for mux4 (WIDTH=1 and WIDTH=8).
// Registered-output checks are compiled when MUX4_REG_OUT_EN is defined.
`timescale 1ns/1ps
module tb_mux4;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst;

  logic       a_i0, a_i1, a_i2, a_i3, a_result;
  logic [1:0] a_sel;
  logic [7:0] b_i0, b_i1, b_i2, b_i3, b_result;
  logic [1:0] b_sel;
  logic [1:0] x_probe;

`ifdef MUX4_REG_OUT_EN
  logic       a_en, a_result_q;
  logic       b_en;
  logic [7:0] b_result_q;
`endif

  int total  = 0;
  int passed = 0;

  always #5 if (clk_run) clk = ~clk;

  mux4 #(.WIDTH(1)) dut_a (
    .result   (a_result),
    .i0       (a_i0),
    .i1       (a_i1),
    .i2       (a_i2),
    .i3       (a_i3),
    .select   (a_sel),
    .clk      (clk),
    .rst      (rst)
`ifdef MUX4_REG_OUT_EN
    ,
    .en       (a_en),
    .result_q (a_result_q)
`endif
  );

  mux4 #(.WIDTH(8)) dut_b (
    .result   (b_result),
    .i0       (b_i0),
    .i1       (b_i1),
    .i2       (b_i2),
    .i3       (b_i3),
    .select   (b_sel),
    .clk      (clk),
    .rst      (rst)
`ifdef MUX4_REG_OUT_EN
    ,
    .en       (b_en),
    .result_q (b_result_q)
`endif
  );

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    rst   = 1'b1;
    a_i0  = 1'b1; a_i1 = 1'b0; a_i2 = 1'b1; a_i3 = 1'b0;
    a_sel = 2'b00;
    b_i0  = 8'hA5; b_i1 = 8'h3C; b_i2 = 8'hFF; b_i3 = 8'h00;
    b_sel = 2'b00;
`ifdef MUX4_REG_OUT_EN
    a_en  = 1'b0;
    b_en  = 1'b0;
`endif
    #3;

    // Combinational path works while reset is asserted.
    check("w1_sel00_in_rst", {7'd0, a_result}, 8'h01);
    check("w8_sel00_in_rst", b_result, 8'hA5);
`ifdef MUX4_REG_OUT_EN
    check("w1_q_reset", {7'd0, a_result_q}, 8'h00);
    check("w8_q_reset", b_result_q, 8'h00);
`endif
    rst = 1'b0;

    // WIDTH=1 walk: i0..i3 = 1,0,1,0.
    a_sel = 2'b00; #1 check("w1_sel00", {7'd0, a_result}, 8'h01); #19;
    a_sel = 2'b01; #1 check("w1_sel01", {7'd0, a_result}, 8'h00); #19;
    a_sel = 2'b10; #1 check("w1_sel10", {7'd0, a_result}, 8'h01); #19;
    a_sel = 2'b11; #1 check("w1_sel11", {7'd0, a_result}, 8'h00); #19;

    // WIDTH=8 vectors.
    b_sel = 2'b11; #1 check("w8_sel11", b_result, 8'h00); #19;
    b_sel = 2'b00; #1 check("w8_sel00", b_result, 8'hA5); #19;
    b_sel = 2'b01; #1 check("w8_sel01", b_result, 8'h3C); #19;
    b_sel = 2'b10; #1 check("w8_sel10", b_result, 8'hFF); #19;

    // Clock stopped: result follows i1 with no edge.
    clk_run = 1'b0;
    b_sel = 2'b01;
    b_i1 = 8'h5A; #1 check("w8_i1_follow_a", b_result, 8'h5A);
    b_i1 = 8'hC3; #1 check("w8_i1_follow_b", b_result, 8'hC3);
    a_sel = 2'b01;
    a_i1 = 1'b1; #1 check("w1_i1_follow_1", {7'd0, a_result}, 8'h01);
    a_i1 = 1'b0; #1 check("w1_i1_follow_0", {7'd0, a_result}, 8'h00);

    // Undefined select yields X (only observable on a 4-state simulator).
    x_probe = 2'bx1;
    b_i0 = 8'hFF; b_i1 = 8'hFF; b_i2 = 8'hFF; b_i3 = 8'hFF;
    b_sel = x_probe; #1;
    if ($isunknown(x_probe)) check("w8_sel_x", b_result, 8'hxx);
    b_i0 = 8'hA5; b_i1 = 8'h3C; b_i2 = 8'hFF; b_i3 = 8'h00;
    b_sel = 2'b00; #1 check("w8_after_x", b_result, 8'hA5);
    clk_run = 1'b1;
    #10;

`ifdef MUX4_REG_OUT_EN
    // Load with en=1, then hold with en=0.
    @(negedge clk);
    a_sel = 2'b10; a_i2 = 1'b1; a_en = 1'b1;
    @(posedge clk); #1 check("q_load", {7'd0, a_result_q}, 8'h01);
    @(negedge clk);
    a_en = 1'b0; a_i2 = 1'b0;
    @(posedge clk); #1 check("q_hold", {7'd0, a_result_q}, 8'h01);

    // Async reset between edges, priority over en.
    @(negedge clk);
    a_i2 = 1'b1; a_en = 1'b1;
    rst = 1'b1; #1 check("q_async_rst", {7'd0, a_result_q}, 8'h00);
    @(posedge clk); #1 check("q_rst_over_en", {7'd0, a_result_q}, 8'h00);
    check("w1_result_in_rst", {7'd0, a_result}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 check("q_first_load", {7'd0, a_result_q}, 8'h01);

    // Coherent capture: new select and new data in the same cycle.
    @(negedge clk);
    b_en = 1'b1; b_sel = 2'b00;
    @(posedge clk); #1 check("q8_load_a5", b_result_q, 8'hA5);
    @(negedge clk);
    b_sel = 2'b11; b_i3 = 8'h96;
    @(posedge clk); #1 check("q8_coherent", b_result_q, 8'h96);
    @(negedge clk);
    b_en = 1'b0; b_i3 = 8'h11;
    @(posedge clk); #1 check("q8_hold", b_result_q, 8'h96);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mux4
